// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier.
// While a multiply is in flight the stage stalls ID and sends bubbles to MEM.
module execute_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              validIn,
  input  logic [3:0]        aluOp,
  input  logic              aluSrc,
  input  logic [WIDTH-1:0]  rsData,
  input  logic [WIDTH-1:0]  rtData,
  input  logic [WIDTH-1:0]  immediate,
  input  logic [REG_AW-1:0] rdIn,
  input  logic [1:0]        writeBackControlIn,
  input  logic [1:0]        memAccessControlIn,
  output logic              stall,
  output logic [1:0]        writeBackControlOut,
  output logic [1:0]        memAccessControlOut,
  output logic [WIDTH-1:0]  resultOut,
  output logic [WIDTH-1:0]  writeData,
  output logic [REG_AW-1:0] rdOut
);

  localparam logic [3:0] OpMul = 4'd10;
  localparam int         CntW  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} stateT;

  stateT            state;
  stateT            nextState;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CntW-1:0]  count;
  logic [WIDTH-1:0] operandB;
  logic [WIDTH-1:0] partial;
  logic             loadAlu;
  logic             startMul;
  logic             stepMul;
  logic             finishMul;

  // Single-cycle ALU; shift amounts always come from the low five bits of B.
  function automatic logic [WIDTH-1:0] aluCompute(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic        [4:0]       sh;
    logic        [WIDTH-1:0] r;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~(a | b);
      4'd6:    r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      4'd7:    r = a << sh;
      4'd8:    r = a >> sh;
      4'd9:    r = $unsigned(sa >>> sh);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign operandB = aluSrc ? immediate : rtData;
  assign partial  = mplier[0] ? mcand : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state: flush aborts any multiply; the last BUSY cycle returns to IDLE.
  always_comb begin
    nextState = state;
    if (reset || flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (validIn && aluOp == OpMul) nextState = BUSY;
        BUSY:    if (count == '0) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Control outputs: stall holds ID until the cycle the product can retire.
  always_comb begin
    stall     = 1'b0;
    loadAlu   = 1'b0;
    startMul  = 1'b0;
    stepMul   = 1'b0;
    finishMul = 1'b0;
    if (!reset && !flush) begin
      case (state)
        IDLE: begin
          if (validIn) begin
            if (aluOp == OpMul) begin
              stall    = 1'b1;
              startMul = 1'b1;
            end else begin
              loadAlu = 1'b1;
            end
          end
        end
        BUSY: begin
          if (count != '0) begin
            stall   = 1'b1;
            stepMul = 1'b1;
          end else begin
            finishMul = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: outputs default to a bubble each edge; multiplier iterates on latched operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      resultOut           <= '0;
      writeData           <= '0;
      rdOut               <= '0;
      writeBackControlOut <= '0;
      memAccessControlOut <= '0;
      count               <= '0;
    end else begin
      resultOut           <= '0;
      writeData           <= '0;
      rdOut               <= '0;
      writeBackControlOut <= '0;
      memAccessControlOut <= '0;
      if (loadAlu || finishMul) begin
        resultOut           <= finishMul ? (acc + partial)
                                         : aluCompute(aluOp, rsData, operandB);
        writeData           <= rtData;
        rdOut               <= rdIn;
        writeBackControlOut <= writeBackControlIn;
        memAccessControlOut <= memAccessControlIn;
      end
      if (startMul) begin
        mcand  <= rsData;
        mplier <= operandB;
        acc    <= '0;
        count  <= CntW'(WIDTH - 1);
      end
      if (stepMul) begin
        acc    <= acc + partial;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CntW'(1);
      end
      if (flush) count <= '0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: a transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_execute_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, flush, validIn, aluSrc;
  logic [3:0]   aluOp;
  logic [W-1:0] rsData, rtData, immediate;
  logic [4:0]   rdIn;
  logic [1:0]   wbIn, memIn;
  logic         stall;
  logic [1:0]   wbOut, memOut;
  logic [W-1:0] resultOut, writeData;
  logic [4:0]   rdOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(W), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .validIn(validIn), .aluOp(aluOp),
    .aluSrc(aluSrc), .rsData(rsData), .rtData(rtData), .immediate(immediate),
    .rdIn(rdIn), .writeBackControlIn(wbIn), .memAccessControlIn(memIn),
    .stall(stall), .writeBackControlOut(wbOut), .memAccessControlOut(memOut),
    .resultOut(resultOut), .writeData(writeData), .rdOut(rdOut)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU straight from the opcode table.
  function automatic logic [W-1:0] aluRef(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  // Model: a multiply occupies the stage for W edges after acceptance, then retires a*b.
  int           mLeft = 0;
  bit           modelReady = 0;
  logic [W-1:0] mProd, eRes, eWd;
  logic [4:0]   eRd;
  logic [1:0]   eWb, eMem;

  task automatic modelBubble();
    eRes = '0; eWd = '0; eRd = '0; eWb = '0; eMem = '0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mLeft = 0; modelBubble(); modelReady = 1;
    end else if (flush) begin
      mLeft = 0; modelBubble();
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin
        eRes = mProd; eWd = rtData; eRd = rdIn; eWb = wbIn; eMem = memIn;
      end else begin
        modelBubble();
      end
    end else if (validIn && aluOp == 4'd10) begin
      mProd = rsData * (aluSrc ? immediate : rtData);
      mLeft = W;
      modelBubble();
    end else if (validIn) begin
      eRes = aluRef(aluOp, rsData, aluSrc ? immediate : rtData);
      eWd = rtData; eRd = rdIn; eWb = wbIn; eMem = memIn;
    end else begin
      modelBubble();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelReady) begin
      check("cyc_stall", W'(stall),
            W'(!reset && !flush && ((mLeft == 0 && validIn && aluOp == 4'd10) || mLeft > 1)));
      check("cyc_result", resultOut, eRes);
      check("cyc_wdata", writeData, eWd);
      check("cyc_rd", W'(rdOut), W'(eRd));
      check("cyc_wb", W'(wbOut), W'(eWb));
      check("cyc_mem", W'(memOut), W'(eMem));
    end
  end

  task automatic setIns(input logic v, input logic [3:0] op, input logic src,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                        input logic [4:0] rd, input logic [1:0] wb, input logic [1:0] mem);
    validIn = v; aluOp = op; aluSrc = src; rsData = a; rtData = b; immediate = imm;
    rdIn = rd; wbIn = wb; memIn = mem;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic runMul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [1:0] wb, input logic [W-1:0] expProd);
    int stallCycles;
    int bubbles;
    bit done;
    stallCycles = 0; bubbles = 0; done = 0;
    setIns(1, 4'd10, 0, a, b, 32'h0, rd, wb, 2'b00);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) begin
        done = 1;
        break;
      end
      stallCycles++;
      step();
      if (resultOut == 0 && writeData == 0 && rdOut == 0 && wbOut == 0 && memOut == 0)
        bubbles++;
    end
    check({tag, "_finished"}, W'(done), 32'd1);
    check({tag, "_stall_cycles"}, W'(stallCycles), 32'd32);
    check({tag, "_bubbles"}, W'(bubbles), 32'd32);
    step();
    check({tag, "_result"}, resultOut, expProd);
    check({tag, "_rd"}, W'(rdOut), W'(rd));
    check({tag, "_wb"}, W'(wbOut), W'(wb));
  endtask

  initial begin
    reset = 1; flush = 0;
    setIns(1, 4'd0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h5, 5'd3, 2'b11, 2'b11);
    step();
    flush = 1;
    setIns(1, 4'd10, 1, 32'hDEAD_BEEF, 32'h7, 32'h3, 5'd17, 2'b01, 2'b10);
    #1;
    check("reset_stall", W'(stall), 32'd0);
    step();
    check("reset_result", resultOut, 32'h0);
    check("reset_rd", W'(rdOut), 32'h0);
    check("reset_ctrl", W'({wbOut, memOut}), 32'h0);

    reset = 0; flush = 0;
    setIns(1, 4'd0, 0, 32'd7, 32'd5, 32'h0, 5'd1, 2'b10, 2'b00);
    step();
    check("add_7_5", resultOut, 32'd12);

    setIns(1, 4'd1, 0, 32'd3, 32'd5, 32'h0, 5'd2, 2'b10, 2'b00);
    step();
    check("sub_3_5", resultOut, 32'hFFFF_FFFE);

    setIns(1, 4'd6, 0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd3, 2'b10, 2'b00);
    step();
    check("slt_m1_1", resultOut, 32'd1);

    setIns(1, 4'd9, 0, 32'h8000_0000, 32'd4, 32'h0, 5'd4, 2'b10, 2'b00);
    step();
    check("sra", resultOut, 32'hF800_0000);

    setIns(1, 4'd0, 1, 32'd20, 32'h55, 32'hFFFF_FFFC, 5'd5, 2'b10, 2'b00);
    step();
    check("add_imm", resultOut, 32'd16);

    setIns(1, 4'd12, 0, 32'hFFFF, 32'h1, 32'h0, 5'd6, 2'b10, 2'b00);
    step();
    check("op12_zero", resultOut, 32'd0);

    setIns(1, 4'd0, 1, 32'd20, 32'hAB, 32'd2, 5'd0, 2'b00, 2'b01);
    step();
    check("store_addr", resultOut, 32'd22);
    check("store_wdata", writeData, 32'hAB);
    check("store_mem", W'(memOut), 32'd1);

    setIns(0, 4'd0, 1, 32'd20, 32'hAB, 32'd2, 5'd0, 2'b00, 2'b01);
    step();
    check("bubble_mem", W'(memOut), 32'd0);
    check("bubble_wdata", writeData, 32'd0);

    runMul("mul_6_7", 32'd6, 32'd7, 5'd9, 2'b10, 32'd42);
    setIns(1, 4'd0, 0, 32'd1, 32'd2, 32'h0, 5'd8, 2'b10, 2'b00);
    step();
    check("add_after_mul", resultOut, 32'd3);
    check("add_after_mul_rd", W'(rdOut), 32'd8);

    runMul("mul_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 2'b10, 32'd1);
    runMul("mul_trunc", 32'h0001_0000, 32'h0001_0000, 5'd11, 2'b10, 32'd0);

    setIns(1, 4'd10, 0, 32'd123, 32'd456, 32'h0, 5'd12, 2'b10, 2'b00);
    step();
    repeat (9) step();
    flush = 1;
    #1;
    check("flush_stall", W'(stall), 32'd0);
    step();
    flush = 0;
    check("flush_bubble", resultOut, 32'd0);
    check("flush_bubble_rd", W'(rdOut), 32'd0);
    setIns(1, 4'd0, 0, 32'd100, 32'd23, 32'h0, 5'd13, 2'b10, 2'b00);
    #1;
    check("post_flush_stall", W'(stall), 32'd0);
    step();
    check("add_after_flush", resultOut, 32'd123);

    setIns(1, 4'd4, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 5'd14, 2'b01, 2'b00);
    step();
    check("xor", resultOut, 32'hFF00_FF00);
    setIns(0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 2'b00);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
